// File: rtl/popcount_window_accumulator.sv
// Counts set bits in each accepted sample and accumulates them over a window of
// WINDOW samples; each window total is offered on a valid/ready output.
module popcount_window_accumulator #(
  parameter int WIDTH    = 4,
  parameter int WINDOW   = 4,
  parameter int ACC_W    = 8,
  parameter int SATURATE = 1,
  localparam int CW      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic [CW-1:0]    last_count
);

  localparam int CNT_W = $clog2(WINDOW + 1);
  localparam int SW    = ACC_W + 1;

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic             out_ovf_q, out_ovf_d;
  logic [CW-1:0]    last_q, last_d;

  logic [CW-1:0]    pc;
  logic [SW-1:0]    sum_wide;
  logic [ACC_W-1:0] acc_upd;
  logic             ovf_upd;

  always_comb begin
    pc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pc = pc + CW'(in_data[i]);
    end
  end

  // One extra bit of headroom exposes the carry that signals overflow.
  always_comb begin
    sum_wide = {1'b0, acc_q} + SW'(pc);
    ovf_upd  = ovf_q | sum_wide[ACC_W];
    acc_upd  = sum_wide[ACC_W-1:0];
    if (sum_wide[ACC_W] && (SATURATE != 0)) begin
      acc_upd = '1;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    last_d      = last_q;
    if (clear) begin
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
      state_d     = ACCUM;
    end else if (state_q == HOLD) begin
      if (out_ready) begin
        out_valid_d = 1'b0;
        state_d     = ACCUM;
      end
    end else if (in_valid) begin
      last_d = pc;
      if (cnt_q == CNT_W'(WINDOW - 1)) begin
        out_sum_d   = acc_upd;
        out_ovf_d   = ovf_upd;
        out_valid_d = 1'b1;
        state_d     = HOLD;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
      end else begin
        acc_d = acc_upd;
        cnt_d = cnt_q + CNT_W'(1);
        ovf_d = ovf_upd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
      last_q      <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
      last_q      <= last_d;
    end
  end

  assign in_ready   = (state_q == ACCUM);
  assign out_valid  = out_valid_q;
  assign out_sum    = out_sum_q;
  assign out_ovf    = out_ovf_q;
  assign last_count = last_q;

endmodule

// File: tb/tb_popcount_window_accumulator.sv
// Self-checking bench: four parameterisations share one clock; hand sequences,
// an exhaustive single-sample table and a randomized run against a window model.
module tb_popcount_window_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   errors = 0;
  int   checks = 0;

  // A: defaults (WINDOW=4, ACC_W=8, saturating)
  logic       a_clear, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf;
  logic [3:0] a_in_data;
  logic [7:0] a_out_sum;
  logic [2:0] a_last;
  // B: WINDOW=1
  logic       b_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf;
  logic [3:0] b_in_data;
  logic [7:0] b_out_sum;
  logic [2:0] b_last;
  // C (saturating) and D (wrapping) with ACC_W=3 share their inputs
  logic       cd_clear, cd_in_valid, cd_out_ready;
  logic [3:0] cd_in_data;
  logic       c_in_ready, c_out_valid, c_out_ovf, d_in_ready, d_out_valid, d_out_ovf;
  logic [2:0] c_out_sum, c_last, d_out_sum, d_last;

  popcount_window_accumulator #(.WIDTH(4), .WINDOW(4), .ACC_W(8), .SATURATE(1)) u_a (
    .clk(clk), .rst(rst), .clear(a_clear), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sum(a_out_sum), .out_ovf(a_out_ovf), .last_count(a_last));

  popcount_window_accumulator #(.WIDTH(4), .WINDOW(1), .ACC_W(8), .SATURATE(1)) u_b (
    .clk(clk), .rst(rst), .clear(b_clear), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_out_sum), .out_ovf(b_out_ovf), .last_count(b_last));

  popcount_window_accumulator #(.WIDTH(4), .WINDOW(4), .ACC_W(3), .SATURATE(1)) u_c (
    .clk(clk), .rst(rst), .clear(cd_clear), .in_valid(cd_in_valid), .in_data(cd_in_data),
    .in_ready(c_in_ready), .out_valid(c_out_valid), .out_ready(cd_out_ready),
    .out_sum(c_out_sum), .out_ovf(c_out_ovf), .last_count(c_last));

  popcount_window_accumulator #(.WIDTH(4), .WINDOW(4), .ACC_W(3), .SATURATE(0)) u_d (
    .clk(clk), .rst(rst), .clear(cd_clear), .in_valid(cd_in_valid), .in_data(cd_in_data),
    .in_ready(d_in_ready), .out_valid(d_out_valid), .out_ready(cd_out_ready),
    .out_sum(d_out_sum), .out_ovf(d_out_ovf), .last_count(d_last));

  typedef struct {
    logic [3:0] data;
    logic [7:0] exp_count;
  } vec_t;

  vec_t vecs[16];
  int   pc_tab[16] = '{0, 1, 1, 2, 1, 2, 2, 3, 1, 2, 2, 3, 2, 3, 3, 4};
  logic [3:0] b2b_seq[4] = '{4'b0000, 4'b0001, 4'b0111, 4'b1111};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_feed(input logic [3:0] d);
    a_in_valid = 1'b1;
    a_in_data  = d;
    tick();
    a_in_valid = 1'b0;
  endtask

  task automatic cd_feed(input logic [3:0] d);
    cd_in_valid = 1'b1;
    cd_in_data  = d;
    tick();
    cd_in_valid = 1'b0;
  endtask

  // Window-level reference: the popcounts of the current window and whether a result is pending.
  int         m_win[$];
  bit         m_pending;
  int         m_sum, m_ovf, m_last;

  task automatic model_step(input logic v, input logic [3:0] d, input logic rdy, input logic clr);
    int total;
    if (clr) begin
      m_win.delete();
      m_pending = 1'b0;
    end else if (m_pending) begin
      if (rdy) m_pending = 1'b0;
    end else if (v) begin
      m_last = $countones(d);
      m_win.push_back(m_last);
      if (m_win.size() == 4) begin
        total = 0;
        foreach (m_win[k]) total += m_win[k];
        m_sum     = (total > 255) ? 255 : total;
        m_ovf     = (total > 255) ? 1 : 0;
        m_pending = 1'b1;
        m_win.delete();
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      vecs[i].data      = 4'(i);
      vecs[i].exp_count = 8'(pc_tab[i]);
    end

    rst = 1'b1;
    a_clear = 0; a_in_valid = 1; a_in_data = 4'b1111; a_out_ready = 0;
    b_clear = 0; b_in_valid = 0; b_in_data = 0; b_out_ready = 0;
    cd_clear = 0; cd_in_valid = 0; cd_in_data = 0; cd_out_ready = 0;
    repeat (3) tick();
    rst = 1'b0;
    a_in_valid = 1'b0;
    check("reset_out_valid", a_out_valid, 0);
    check("reset_out_sum", a_out_sum, 0);
    check("reset_out_ovf", a_out_ovf, 0);
    check("reset_last_count", a_last, 0);
    check("reset_in_ready", a_in_ready, 1);

    // Exhaustive single samples with WINDOW=1
    b_out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = vecs[i].data;
      tick();
      b_in_valid = 1'b0;
      $display("vec %0d data=%b out_sum=%0d last_count=%0d", i, vecs[i].data, b_out_sum, b_last);
      check("w1_out_valid", b_out_valid, 1);
      check("w1_out_sum", b_out_sum, vecs[i].exp_count);
      check("w1_last_count", b_last, vecs[i].exp_count);
      check("w1_out_ovf", b_out_ovf, 0);
      tick();
      check("w1_valid_pulse", b_out_valid, 0);
      check("w1_in_ready", b_in_ready, 1);
    end

    // Back-to-back window, then backpressure
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) a_out_ready = 1'b0;
      a_feed(b2b_seq[i]);
      if (i < 3) check("b2b_early_valid", a_out_valid, 0);
    end
    $display("window b2b: out_sum=%0d out_ovf=%0d", a_out_sum, a_out_ovf);
    check("b2b_out_valid", a_out_valid, 1);
    check("b2b_out_sum", a_out_sum, 8);
    check("b2b_out_ovf", a_out_ovf, 0);
    check("b2b_last_count", a_last, 4);
    check("b2b_in_ready", a_in_ready, 0);
    a_in_valid = 1'b1;
    a_in_data  = 4'b0001;
    repeat (5) begin
      tick();
      check("bp_out_valid", a_out_valid, 1);
      check("bp_out_sum", a_out_sum, 8);
      check("bp_in_ready", a_in_ready, 0);
    end
    check("bp_last_count", a_last, 4);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    tick();
    check("hs_out_valid", a_out_valid, 0);
    check("hs_in_ready", a_in_ready, 1);
    repeat (4) a_feed(4'b0001);
    check("next_win_sum", a_out_sum, 4);
    check("next_win_valid", a_out_valid, 1);
    tick();
    check("next_win_hs", a_out_valid, 0);

    // Gapped input
    for (int i = 0; i < 7; i++) begin
      a_in_valid = (i % 2 == 0);
      a_in_data  = 4'b0011;
      tick();
      if (i < 6) check("gap_early_valid", a_out_valid, 0);
    end
    a_in_valid = 1'b0;
    $display("window gapped: out_sum=%0d", a_out_sum);
    check("gap_out_valid", a_out_valid, 1);
    check("gap_out_sum", a_out_sum, 8);
    tick();

    // clear mid-window, then clear while holding a result
    a_feed(4'b1111);
    a_feed(4'b1111);
    a_clear = 1'b1;
    a_feed(4'b0001);
    a_clear = 1'b0;
    check("clr_last_count", a_last, 4);
    check("clr_in_ready", a_in_ready, 1);
    a_out_ready = 1'b0;
    repeat (4) a_feed(4'b0011);
    check("clr_win_sum", a_out_sum, 8);
    check("clr_win_valid", a_out_valid, 1);
    a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
    check("clr_hold_valid", a_out_valid, 0);
    check("clr_hold_ready", a_in_ready, 1);
    a_out_ready = 1'b1;
    repeat (4) a_feed(4'b0001);
    check("clr_after_sum", a_out_sum, 4);
    tick();

    // Overflow with ACC_W=3
    cd_out_ready = 1'b1;
    repeat (4) cd_feed(4'b1111);
    $display("window ovf: sat sum=%0d ovf=%0d wrap sum=%0d ovf=%0d",
             c_out_sum, c_out_ovf, d_out_sum, d_out_ovf);
    check("sat_valid", c_out_valid, 1);
    check("sat_sum", c_out_sum, 7);
    check("sat_ovf", c_out_ovf, 1);
    check("wrap_valid", d_out_valid, 1);
    check("wrap_sum", d_out_sum, 0);
    check("wrap_ovf", d_out_ovf, 1);
    tick();
    repeat (4) cd_feed(4'b0001);
    check("sat_next_sum", c_out_sum, 4);
    check("sat_next_ovf", c_out_ovf, 0);
    check("wrap_next_sum", d_out_sum, 4);
    check("wrap_next_ovf", d_out_ovf, 0);
    tick();

    // Randomized run against the window model
    a_clear = 1'b1;
    tick();
    a_clear   = 1'b0;
    m_win.delete();
    m_pending = 1'b0;
    m_last    = 1;
    m_sum     = 0;
    m_ovf     = 0;
    for (int n = 0; n < 400; n++) begin
      a_in_valid  = ($urandom_range(0, 3) != 0);
      a_in_data   = 4'($urandom);
      a_out_ready = ($urandom_range(0, 2) != 0);
      a_clear     = ($urandom_range(0, 40) == 0);
      model_step(a_in_valid, a_in_data, a_out_ready, a_clear);
      tick();
      check("rnd_out_valid", a_out_valid, 32'(m_pending));
      check("rnd_in_ready", a_in_ready, 32'(!m_pending));
      check("rnd_last_count", a_last, m_last);
      if (m_pending) begin
        check("rnd_out_sum", a_out_sum, m_sum);
        check("rnd_out_ovf", a_out_ovf, m_ovf);
      end
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    a_clear     = 1'b1;
    tick();
    a_clear = 1'b0;

    // rst mid-window, then rst together with clear
    a_feed(4'b1111);
    a_feed(4'b1111);
    rst        = 1'b1;
    a_in_valid = 1'b1;
    tick();
    rst        = 1'b0;
    a_in_valid = 1'b0;
    check("rst_mid_valid", a_out_valid, 0);
    check("rst_mid_sum", a_out_sum, 0);
    check("rst_mid_ovf", a_out_ovf, 0);
    check("rst_mid_last", a_last, 0);
    check("rst_mid_ready", a_in_ready, 1);
    a_feed(4'b0111);
    check("pre_rstclr_last", a_last, 3);
    rst     = 1'b1;
    a_clear = 1'b1;
    tick();
    rst     = 1'b0;
    a_clear = 1'b0;
    check("rstclr_last", a_last, 0);
    check("rstclr_valid", a_out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      a_feed(4'b0011);
      if (i < 3) check("post_rst_early_valid", a_out_valid, 0);
    end
    check("post_rst_sum", a_out_sum, 8);
    check("post_rst_valid", a_out_valid, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
